// File: rtl/uart_char_receiver.sv
// uart_char_receiver: 8N1 UART deserialiser driving cout/we for the character feeder.
// Define UART_PARITY_EN for 8E1 frames with a parity_err pulse output.
module uart_char_receiver #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] cout,
  output logic       we,
  output logic       frame_err,
`ifdef UART_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);
  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int TW  = $clog2(DIV + 1);
  localparam int SW  = $clog2(OVERSAMPLE + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t state, state_n;
  logic r1, rs, rs_d;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] scnt;
  logic [2:0] idx;
  logic [7:0] shift;
  logic run, tick, samp, we_n, ferr_n;
`ifdef UART_PARITY_EN
  logic pbad, perr_n;
`endif
  assign run  = state inside {START, DATA, PARITY, STOP};
  assign tick = run && tcnt == TW'(DIV - 1);
  // START samples half a bit in; later states sample a full bit after the previous sample
  assign samp = tick && scnt == (state == START ? SW'(OVERSAMPLE / 2 - 1) : SW'(OVERSAMPLE - 1));
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (!rs && rs_d) state_n = START;
      START:  if (samp) state_n = rs ? IDLE : DATA;
`ifdef UART_PARITY_EN
      DATA:   if (samp && idx == 3'd7) state_n = PARITY;
      PARITY: if (samp) state_n = STOP;
`else
      DATA:   if (samp && idx == 3'd7) state_n = STOP;
`endif
      STOP:   if (samp) state_n = rs ? IDLE : BREAK;
      BREAK:  if (rs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
`ifdef UART_PARITY_EN
    we_n   = state == STOP && samp && rs && !pbad;
    perr_n = state == STOP && samp && rs && pbad;
`else
    we_n   = state == STOP && samp && rs;
`endif
    ferr_n = state == STOP && samp && !rs;
    busy   = state != IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {rs_d, rs, r1} <= 3'b111;
      tcnt      <= '0;
      scnt      <= '0;
      idx       <= '0;
      shift     <= '0;
      cout      <= '0;
      we        <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      pbad       <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      {rs_d, rs, r1} <= {rs, r1, rx};
      tcnt <= (!run || tick) ? '0 : tcnt + 1'b1;
      scnt <= (!run || samp) ? '0 : tick ? scnt + 1'b1 : scnt;
      idx  <= state != DATA ? '0 : samp ? idx + 1'b1 : idx;
      if (state == DATA && samp) shift <= {rs, shift[7:1]};
      if (we_n) cout <= shift;
      we        <= we_n;
      frame_err <= ferr_n;
`ifdef UART_PARITY_EN
      if (state == PARITY && samp) pbad <= ^shift ^ rs;
      parity_err <= perr_n;
`endif
    end
endmodule

// File: tb/tb_uart_char_receiver.sv
// tb_uart_char_receiver: table-driven check of the UART receiver at DIV=10, 160 clk per bit.
module tb_uart_char_receiver;
  localparam int BIT = 160;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0, reset = 1'b1, rx = 1'b1;
  logic [7:0] cout;
  logic we, frame_err, busy;
`ifdef UART_PARITY_EN
  logic parity_err;
`endif
  int n_cmp = 0, n_bad = 0;
  int we_cnt = 0, fe_cnt = 0, pe_cnt = 0, both_cnt = 0, cyc = 0, we_cyc = 0, prev_we_cyc = 0;
  logic busy_mid;

  uart_char_receiver #(.CLK_HZ(1600000), .BAUD(10000), .OVERSAMPLE(16)) dut (
    .clk(clk), .reset(reset), .rx(rx), .cout(cout), .we(we), .frame_err(frame_err),
`ifdef UART_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (we) begin we_cnt++; prev_we_cyc = we_cyc; we_cyc = cyc; end
    if (frame_err) fe_cnt++;
    if (we && frame_err) both_cnt++;
`ifdef UART_PARITY_EN
    if (parity_err) pe_cnt++;
`endif
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    logic [10:0] bits;
`ifdef UART_PARITY_EN
    bits = {stop, p, d, 1'b0};
`else
    bits = {p & 1'b0, stop, d, 1'b0};
`endif
    for (int i = 0; i < NB; i++) begin
      rx = bits[i];
      repeat (BIT / 2) @(posedge clk);
      #1;
      if (i == 4) busy_mid = busy;
      repeat (BIT / 2) @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       stop;
    int         glitch;
    int         hold;
    int         gap;
    bit         chk_iv;
    int         e_we;
    int         e_fe;
    int         e_pe;
    logic [7:0] e_cout;
  } vec_t;
  vec_t tbl[$];

  initial begin
    int w0, f0, p0;
    tbl.push_back('{8'h41, 1'b0, 1'b1, 0,  0,    200, 1'b0, 1, 0, 0, 8'h41});
    tbl.push_back('{8'h48, 1'b0, 1'b1, 0,  0,    200, 1'b0, 1, 0, 0, 8'h48});
    tbl.push_back('{8'h48, 1'b0, 1'b1, 0,  0,    0,   1'b0, 1, 0, 0, 8'h48});
    tbl.push_back('{8'h49, 1'b1, 1'b1, 0,  0,    200, 1'b1, 1, 0, 0, 8'h49});
    tbl.push_back('{8'h30, 1'b0, 1'b1, 40, 0,    200, 1'b0, 1, 0, 0, 8'h30});
    tbl.push_back('{8'h7E, 1'b0, 1'b0, 0,  3000, 200, 1'b0, 0, 1, 0, 8'h30});
    tbl.push_back('{8'h21, 1'b0, 1'b1, 0,  0,    200, 1'b0, 1, 0, 0, 8'h21});
`ifdef UART_PARITY_EN
    tbl.push_back('{8'h03, 1'b0, 1'b1, 0,  0,    200, 1'b0, 1, 0, 0, 8'h03});
    tbl.push_back('{8'h03, 1'b1, 1'b1, 0,  0,    200, 1'b0, 0, 0, 1, 8'h03});
`endif
    repeat (5) @(posedge clk);
    #1;
    chk("rst_cout", cout, 0);
    chk("rst_we", we, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (BIT) @(posedge clk);
      #1;
      rx = i < 3 ? 1'(8'h5A >> i) : 1'b1;
    end
    chk("busy_before_abort", busy, 1);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("inrst_cout", cout, 0);
    chk("inrst_we", we, 0);
    chk("inrst_ferr", frame_err, 0);
    chk("inrst_busy", busy, 0);
    rx = 1'b1;
    reset = 1'b0;
    repeat (1600) @(posedge clk);
    #1;
    chk("aborted_no_we", we_cnt, 0);
    chk("aborted_no_ferr", fe_cnt, 0);
    foreach (tbl[k]) begin
      if (tbl[k].glitch > 0) begin
        w0 = we_cnt; f0 = fe_cnt;
        rx = 1'b0;
        repeat (tbl[k].glitch) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        chk("glitch_we", we_cnt - w0, 0);
        chk("glitch_ferr", fe_cnt - f0, 0);
        chk("glitch_idle", busy, 0);
      end
      w0 = we_cnt; f0 = fe_cnt; p0 = pe_cnt;
      busy_mid = 1'b0;
      send_frame(tbl[k].d, tbl[k].p, tbl[k].stop);
      chk($sformatf("v%0d_busy_mid", k), busy_mid, 1);
      if (tbl[k].hold > 0) begin
        repeat (tbl[k].hold) @(posedge clk);
        #1;
        chk($sformatf("v%0d_break_busy", k), busy, 1);
        rx = 1'b1;
      end
      chk($sformatf("v%0d_we", k), we_cnt - w0, tbl[k].e_we);
      chk($sformatf("v%0d_ferr", k), fe_cnt - f0, tbl[k].e_fe);
      chk($sformatf("v%0d_cout", k), cout, tbl[k].e_cout);
`ifdef UART_PARITY_EN
      chk($sformatf("v%0d_perr", k), pe_cnt - p0, tbl[k].e_pe);
`endif
      if (tbl[k].chk_iv) chk("we_interval", we_cyc - prev_we_cyc, BIT * NB);
      repeat (tbl[k].gap) @(posedge clk);
      #1;
      if (tbl[k].gap > 0) chk($sformatf("v%0d_idle", k), busy, 0);
    end
    chk("we_ferr_overlap", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
